// File: rtl/wb_queue.sv
// Write-back queue: merges ALU and load results into a single register-file
// write port. Each cycle it accepts up to two results, drains one entry, keeps
// a pending-destination mask for decode hazard checks, counts acknowledged
// writes and raises a sticky flag when the acknowledge handshake is broken.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [2:0]  ex_dest,
    input  logic [15:0] ex_data,
    output logic        ex_ready,
    input  logic        mem_valid,
    input  logic [2:0]  mem_dest,
    input  logic [15:0] mem_data,
    output logic        mem_ready,
    output logic        rf_wr,
    output logic [2:0]  rf_dest,
    output logic [15:0] rf_data,
    input  logic        rf_wr_success,
    output logic [7:0]  pending_mask,
    output logic [15:0] retire_cnt,
    output logic        wb_err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] free;
    logic [2:0]       dest_q [DEPTH];
    logic [2:0]       dest_d [DEPTH];
    logic [15:0]      data_q [DEPTH];
    logic [15:0]      data_d [DEPTH];
    logic [15:0]      retire_cnt_q, retire_cnt_d;
    logic             wb_err_q, wb_err_d;
    logic             wr_hist_q, wr_hist_d;
    logic             push_mem, push_ex, pop;
    logic [PTR_W-1:0] ex_slot;
    logic [PTR_W-1:0] slot_off;

    // Readiness from registered occupancy only; the load port has priority
    // for the last free slot so a load is never starved by an ALU result.
    always_comb begin
        free      = DEPTH_C - count_q;
        mem_ready = !rst && (free >= CNT_W'(1));
        ex_ready  = !rst && ((free >= CNT_W'(2)) ||
                             ((free == CNT_W'(1)) && !mem_valid));
        push_mem  = mem_valid && mem_ready;
        push_ex   = ex_valid && ex_ready;
        pop       = (count_q != '0);
    end

    // Entry writes: on a dual accept the load is older, so it takes wr_ptr
    // and the ALU result takes the slot after it.
    always_comb begin
        dest_d  = dest_q;
        data_d  = data_q;
        ex_slot = push_mem ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        if (push_mem) begin
            dest_d[wr_ptr_q] = mem_dest;
            data_d[wr_ptr_q] = mem_data;
        end
        if (push_ex) begin
            dest_d[ex_slot] = ex_dest;
            data_d[ex_slot] = ex_data;
        end
    end

    // Pointer, occupancy and retire/handshake bookkeeping.
    always_comb begin
        rd_ptr_d     = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        wr_ptr_d     = wr_ptr_q + PTR_W'(push_mem) + PTR_W'(push_ex);
        count_d      = count_q + CNT_W'(push_mem) + CNT_W'(push_ex) - CNT_W'(pop);
        retire_cnt_d = rf_wr_success ? (retire_cnt_q + 16'd1) : retire_cnt_q;
        wr_hist_d    = pop;
        wb_err_d     = wb_err_q | (wr_hist_q != rf_wr_success);
    end

    // Register-file port and hazard mask; both forced quiet while in reset
    // so discarded entries never appear on the write port.
    always_comb begin
        rf_wr        = pop && !rst;
        rf_dest      = dest_q[rd_ptr_q];
        rf_data      = data_q[rd_ptr_q];
        pending_mask = '0;
        slot_off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - rd_ptr_q;
            if (!rst && ({1'b0, slot_off} < count_q)) begin
                pending_mask[dest_q[i]] = 1'b1;
            end
        end
        retire_cnt = retire_cnt_q;
        wb_err     = wb_err_q;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            retire_cnt_q <= '0;
            wb_err_q     <= 1'b0;
            wr_hist_q    <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            retire_cnt_q <= retire_cnt_d;
            wb_err_q     <= wb_err_d;
            wr_hist_q    <= wr_hist_d;
        end
    end

    // Entry storage is never reset; occupancy alone decides visibility.
    always_ff @(posedge clk) begin
        dest_q <= dest_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios followed by random
// traffic, checked by a queue-based reference model and a separate monitor
// that consumes expected register-file writes.
module tb_wb_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_dest = '0;
    logic [15:0] ex_data = '0;
    logic        ex_ready;
    logic        mem_valid = 1'b0;
    logic [2:0]  mem_dest = '0;
    logic [15:0] mem_data = '0;
    logic        mem_ready;
    logic        rf_wr;
    logic [2:0]  rf_dest;
    logic [15:0] rf_data;
    logic        rf_wr_success;
    logic [7:0]  pending_mask;
    logic [15:0] retire_cnt;
    logic        wb_err;

    logic        ack_q = 1'b0;
    logic        nack = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    // reference model state
    logic [18:0] fifo[$];
    logic [18:0] exp_q[$];
    logic [15:0] m_ret = '0;
    logic        m_err = 1'b0;
    logic        m_hist = 1'b0;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_data(ex_data), .ex_ready(ex_ready),
        .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_wr(rf_wr), .rf_dest(rf_dest), .rf_data(rf_data), .rf_wr_success(rf_wr_success),
        .pending_mask(pending_mask), .retire_cnt(retire_cnt), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // register file: acknowledges one cycle after each write, unless suppressed
    always @(posedge clk) ack_q <= rf_wr;
    assign rf_wr_success = ack_q & ~nack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // one clock cycle of stimulus plus model update
    task automatic cyc(input logic r, input logic mv, input logic [2:0] md, input logic [15:0] mdat,
                       input logic ev, input logic [2:0] ed, input logic [15:0] edat, input logic nk);
        int free;
        logic m_rdy, e_rdy, ack, macc, eacc, was_busy;
        logic [7:0] pm;
        @(negedge clk);
        rst = r; mem_valid = mv; mem_dest = md; mem_data = mdat;
        ex_valid = ev; ex_dest = ed; ex_data = edat; nack = nk;
        #1;
        free  = DEPTH - fifo.size();
        m_rdy = !r && (free >= 1);
        e_rdy = !r && ((free >= 2) || ((free == 1) && !mv));
        pm = '0;
        if (!r) foreach (fifo[k]) pm[fifo[k][18:16]] = 1'b1;
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, m_rdy});
        chk("ex_ready", {31'd0, ex_ready}, {31'd0, e_rdy});
        chk("pending_mask", {24'd0, pending_mask}, {24'd0, pm});
        chk("retire_cnt", {16'd0, retire_cnt}, {16'd0, m_ret});
        chk("wb_err", {31'd0, wb_err}, {31'd0, m_err});
        ack  = rf_wr_success;
        macc = mv && m_rdy;
        eacc = ev && e_rdy;
        was_busy = (fifo.size() != 0);
        @(posedge clk);
        if (r) begin
            fifo.delete();
            exp_q.delete();
            m_ret  = '0;
            m_err  = 1'b0;
            m_hist = 1'b0;
        end else begin
            if (ack != m_hist) m_err = 1'b1;
            if (ack) m_ret = m_ret + 16'd1;
            m_hist = was_busy;
            if (was_busy) void'(fifo.pop_front());
            if (macc) begin
                fifo.push_back({md, mdat});
                exp_q.push_back({md, mdat});
            end
            if (eacc) begin
                fifo.push_back({ed, edat});
                exp_q.push_back({ed, edat});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
    endtask

    // monitor: every presented write must match the oldest expected one
    initial begin
        logic exp_wr;
        logic [18:0] e;
        forever begin
            @(negedge clk);
            #2;
            exp_wr = !rst && (exp_q.size() != 0);
            chk("rf_wr", {31'd0, rf_wr}, {31'd0, exp_wr});
            if (exp_wr) begin
                e = exp_q.pop_front();
                if (rf_wr) begin
                    chk("rf_dest", {29'd0, rf_dest}, {29'd0, e[18:16]});
                    chk("rf_data", {16'd0, rf_data}, {16'd0, e[15:0]});
                end
            end
        end
    end

    initial begin
        logic r, mv, ev, nk;
        // reset
        repeat (3) cyc(1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
        idle(1);
        // single ALU push into empty queue
        cyc(1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 3'd3, 16'h1234, 1'b0);
        idle(3);
        // dual push: load older than ALU result
        cyc(1'b0, 1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555, 1'b0);
        idle(3);
        // fill to three entries, then both valid: only the load fits
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 3'(i), 16'($urandom), 1'b1, 3'(7 - i), 16'($urandom), 1'b0);
        idle(6);
        // ten back-to-back ALU pushes, pointers wrap
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 3'(i % 8), 16'(16'h0100 + i), 1'b0);
        idle(4);
        // missing acknowledge sets the sticky error
        cyc(1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 3'd5, 16'hBEEF, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1);
        idle(4);
        // fill three entries then reset: they must vanish
        cyc(1'b0, 1'b1, 3'd0, 16'h0A0A, 1'b1, 3'd7, 16'h0B0B, 1'b0);
        cyc(1'b0, 1'b1, 3'd4, 16'h0C0C, 1'b1, 3'd6, 16'h0D0D, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
        idle(4);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            mv = ($urandom_range(0, 2) != 0);
            ev = ($urandom_range(0, 2) != 0);
            nk = ($urandom_range(0, 99) == 0);
            cyc(r, mv, 3'($urandom), 16'($urandom), ev, 3'($urandom), 16'($urandom), nk);
        end
        idle(8);
        chk("drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
